mem_access_unit: RTL

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_pkg.sv | 26 ++
 rtl/mem_lane_align.sv | 43 ++++
 rtl/mem_access_unit.sv | 127 ++++++++++++
 3 files changed

// File: rtl/mem_access_pkg.sv
// Shared op encodings, FSM state type and helpers for mem_access_unit.
package mem_access_pkg;

  typedef logic [2:0] mem_op_t;

  localparam mem_op_t OP_LB  = 3'b000;
  localparam mem_op_t OP_LH  = 3'b001;
  localparam mem_op_t OP_LW  = 3'b010;
  localparam mem_op_t OP_LBU = 3'b011;
  localparam mem_op_t OP_LHU = 3'b100;
  localparam mem_op_t OP_SB  = 3'b101;
  localparam mem_op_t OP_SH  = 3'b110;
  localparam mem_op_t OP_SW  = 3'b111;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_RD      = 2'd1;
  localparam state_t ST_RD_WAIT = 2'd2;
  localparam state_t ST_WR      = 2'd3;

  function automatic logic op_is_store(input mem_op_t op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational little-endian lane extraction for loads and lane merge for
// partial stores.
module mem_lane_align
  import mem_access_pkg::*;
(
  input  mem_op_t     op_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] mem_word_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_data_o,
  output logic [31:0] merged_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = mem_word_i[{addr_lo_i, 3'b000} +: 8];
    half_sel = addr_lo_i[1] ? mem_word_i[31:16] : mem_word_i[15:0];

    load_data_o = '0;
    case (op_i)
      OP_LB:   load_data_o = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  load_data_o = {24'h0, byte_sel};
      OP_LH:   load_data_o = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  load_data_o = {16'h0, half_sel};
      OP_LW:   load_data_o = mem_word_i;
      default: load_data_o = '0;
    endcase

    // Partial stores keep every byte of the fetched word outside the lane.
    merged_o = mem_word_i;
    case (op_i)
      OP_SB: merged_o[{addr_lo_i, 3'b000} +: 8] = wdata_i[7:0];
      OP_SH: begin
        if (addr_lo_i[1]) merged_o[31:16] = wdata_i[15:0];
        else              merged_o[15:0]  = wdata_i[15:0];
      end
      default: merged_o = wdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit: byte/half/word loads, SW direct write, SB/SH read-modify-write.
// Optional MEM_ACCESS_MISALIGN_TRAP_EN adds a misalign trap output.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int MEM_DEPTH_LOG2 = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic [2:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic        done,
  output logic [31:0] rdata,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data,
  input  logic [31:0] mem_out,
  output logic [1:0]  dbg_state_o
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
  ,
  output logic        misalign
`endif
);

  // Handshake: req is sampled only on a rising edge where ready=1 (state IDLE);
  // done pulses for one cycle per accepted request, rdata valid only then.

  state_t      state_q, state_d;
  mem_op_t     op_q;
  logic [1:0]  addr_lo_q;
  logic [31:0] wdata_q;
  logic        mem_rd_q, mem_wr_q, done_q;
  logic [31:0] mem_addr_q, mem_data_q;
  logic        accept, mis_now;
  logic [31:0] load_data, merged;
  logic        unused_addr_hi;

  assign unused_addr_hi = ^addr[31:MEM_DEPTH_LOG2+2];
  assign accept = (state_q == ST_IDLE) && req;

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
  always_comb begin
    mis_now = 1'b0;
    if ((op == OP_LH || op == OP_LHU || op == OP_SH) && addr[0]) mis_now = 1'b1;
    if ((op == OP_LW || op == OP_SW) && (addr[1:0] != 2'b00))   mis_now = 1'b1;
  end
`else
  assign mis_now = 1'b0;
`endif

  mem_lane_align u_align (
    .op_i       (op_q),
    .addr_lo_i  (addr_lo_q),
    .mem_word_i (mem_out),
    .wdata_i    (wdata_q),
    .load_data_o(load_data),
    .merged_o   (merged)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        // A trapped access reuses WR as its one-cycle completion state.
        if (req) state_d = (mis_now || op == OP_SW) ? ST_WR : ST_RD;
      end
      ST_RD:      state_d = ST_RD_WAIT;
      ST_RD_WAIT: state_d = op_is_store(op_q) ? ST_WR : ST_IDLE;
      ST_WR:      state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      op_q       <= OP_LB;
      addr_lo_q  <= '0;
      wdata_q    <= '0;
      mem_rd_q   <= 1'b0;
      mem_wr_q   <= 1'b0;
      done_q     <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
    end else begin
      state_q  <= state_d;
      mem_rd_q <= (state_d == ST_RD);
      mem_wr_q <= (state_d == ST_WR) && !(accept && mis_now);
      done_q   <= (state_d == ST_WR) ||
                  ((state_d == ST_RD_WAIT) && !op_is_store(op_q));
      if (accept) begin
        op_q       <= op;
        addr_lo_q  <= addr[1:0];
        wdata_q    <= wdata;
        mem_addr_q <= 32'(addr[MEM_DEPTH_LOG2+1:2]);
        if (op == OP_SW) mem_data_q <= wdata;
      end else if (state_q == ST_RD_WAIT && op_is_store(op_q)) begin
        mem_data_q <= merged;
      end
    end
  end

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
  logic misalign_q;

  always_ff @(posedge clk) begin
    if (rst) misalign_q <= 1'b0;
    else     misalign_q <= accept && mis_now;
  end

  assign misalign = misalign_q;
`endif

  assign ready       = (state_q == ST_IDLE);
  assign done        = done_q;
  assign rdata       = (done_q && state_q == ST_RD_WAIT) ? load_data : 32'h0;
  assign mem_rd      = mem_rd_q;
  assign mem_wr      = mem_wr_q;
  assign mem_addr    = mem_addr_q;
  assign mem_data    = mem_data_q;
  assign dbg_state_o = state_q;

endmodule
